// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped BTB with zero-latency lookup and execute-stage
//               update. Define BTB_TWO_BIT_COUNTER_EN for 2-bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_if,
    input  logic [XLEN-1:0] pc_ex,
    input  logic            update_ex,
    input  logic            branch_taken_ex,
    input  logic [XLEN-1:0] target_addr_ex,
    output logic [XLEN-1:0] predicted_target,
    output logic            predict_taken,
    output logic            hit
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    logic [IDXW-1:0]    if_idx, ex_idx;
    logic [TAGW-1:0]    if_tag, ex_tag;
    logic               ex_match;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [TAGW-1:0]    tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];

    // Instruction alignment bits never select an entry.
    logic               unused_pc_bits;
    assign unused_pc_bits = ^{pc_if[1:0], pc_ex[1:0]};

    assign if_idx   = pc_if[IDXW+1:2];
    assign if_tag   = pc_if[XLEN-1:IDXW+2];
    assign ex_idx   = pc_ex[IDXW+1:2];
    assign ex_tag   = pc_ex[XLEN-1:IDXW+2];
    assign ex_match = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (update_ex) begin
            if (branch_taken_ex) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = target_addr_ex;
            end
`ifndef BTB_TWO_BIT_COUNTER_EN
            else if (ex_match) begin
                valid_d[ex_idx] = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and target need no reset: they are only observed through valid.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

`ifdef BTB_TWO_BIT_COUNTER_EN
    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    always_comb begin
        ctr_d = ctr_q;
        if (update_ex) begin
            if (branch_taken_ex) begin
                if (!ex_match) begin
                    ctr_d[ex_idx] = 2'd2;
                end else if (ctr_q[ex_idx] != 2'd3) begin
                    ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
                end
            end else if (ex_match && (ctr_q[ex_idx] != 2'd0)) begin
                ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_q <= '{default: 2'd1};
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign predict_taken = hit && ctr_q[if_idx][1];
`else
    assign predict_taken = hit;
`endif

    assign hit              = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign predicted_target = predict_taken ? target_q[if_idx] : (pc_if + XLEN'(4));

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_target_buffer
// Description : Scoreboard bench for branch_target_buffer against a
//               behavioural table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] pc_if = '0;
    logic [63:0] pc_ex = '0;
    logic        update_ex = 1'b0;
    logic        branch_taken_ex = 1'b0;
    logic [63:0] target_addr_ex = '0;
    logic [63:0] predicted_target;
    logic        predict_taken;
    logic        hit;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        hit;
        logic        pt;
        logic [63:0] tgt;
    } exp_t;

    exp_t sb[$];

    bit          m_valid [64];
    logic [55:0] m_tag   [64];
    logic [63:0] m_tgt   [64];
    int          m_ctr   [64];

    branch_target_buffer #(.XLEN(64), .ENTRIES(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_if            (pc_if),
        .pc_ex            (pc_ex),
        .update_ex        (update_ex),
        .branch_taken_ex  (branch_taken_ex),
        .target_addr_ex   (target_addr_ex),
        .predicted_target (predicted_target),
        .predict_taken    (predict_taken),
        .hit              (hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_lookup(input logic [63:0] pc);
        exp_t e;
        int   i;
        i     = int'(pc[7:2]);
        e.hit = m_valid[i] && (m_tag[i] == pc[63:8]);
`ifdef BTB_TWO_BIT_COUNTER_EN
        e.pt  = e.hit && (m_ctr[i] >= 2);
`else
        e.pt  = e.hit;
`endif
        e.tgt = e.pt ? m_tgt[i] : pc + 64'd4;
        return e;
    endfunction

    task automatic model_update(input logic [63:0] pc, input bit taken, input logic [63:0] tgt);
        int i;
        bit match;
        i     = int'(pc[7:2]);
        match = m_valid[i] && (m_tag[i] == pc[63:8]);
        if (taken) begin
            m_ctr[i]   = match ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : 2;
            m_valid[i] = 1'b1;
            m_tag[i]   = pc[63:8];
            m_tgt[i]   = tgt;
        end else if (match) begin
`ifdef BTB_TWO_BIT_COUNTER_EN
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
`else
            m_valid[i] = 1'b0;
`endif
        end
    endtask

    // One cycle: drive lookup and optional update, check the pre-edge lookup,
    // then fold the update into the model for the following cycle.
    task automatic step(input logic [63:0] look, input bit upd, input logic [63:0] pc,
                        input bit taken, input logic [63:0] tgt,
                        input bit dir, input bit e_hit, input bit e_pt, input logic [63:0] e_tgt);
        exp_t e;
        @(posedge clk);
        #1;
        pc_if           = look;
        update_ex       = upd;
        pc_ex           = pc;
        branch_taken_ex = taken;
        target_addr_ex  = tgt;
        sb.push_back(model_lookup(look));
        @(negedge clk);
        e = sb.pop_front();
        check("hit", {63'd0, hit}, {63'd0, e.hit});
        check("predict_taken", {63'd0, predict_taken}, {63'd0, e.pt});
        check("predicted_target", predicted_target, e.tgt);
        if (dir) begin
            check("dir_hit", {63'd0, hit}, {63'd0, e_hit});
            check("dir_predict_taken", {63'd0, predict_taken}, {63'd0, e_pt});
            check("dir_predicted_target", predicted_target, e_tgt);
        end
        if (upd) model_update(pc, taken, tgt);
    endtask

    task automatic look(input logic [63:0] pc, input bit e_hit, input bit e_pt, input logic [63:0] e_tgt);
        step(pc, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1, e_hit, e_pt, e_tgt);
    endtask

    task automatic upd(input logic [63:0] pc, input bit taken, input logic [63:0] tgt);
        step(pc, 1'b1, pc, taken, tgt, 1'b0, 1'b0, 1'b0, 64'd0);
    endtask

    // Reset, optionally with a taken update presented in the same cycles.
    task automatic do_reset(input bit with_update);
        @(posedge clk);
        #1;
        reset           = 1'b1;
        update_ex       = with_update;
        pc_ex           = 64'h1000;
        branch_taken_ex = 1'b1;
        target_addr_ex  = 64'h2000;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        update_ex = 1'b0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] pool [6];
        pool = '{64'h1000, 64'h1004, 64'h1100, 64'h1104, 64'h2000, 64'h3F00};

        do_reset(1'b1);
        look(64'h1000, 1'b0, 1'b0, 64'h1004);

        // Same-cycle update and lookup sees the pre-update entry.
        step(64'h1000, 1'b1, 64'h1000, 1'b1, 64'h2000, 1'b1, 1'b0, 1'b0, 64'h1004);
        look(64'h1000, 1'b1, 1'b1, 64'h2000);

`ifdef BTB_TWO_BIT_COUNTER_EN
        upd(64'h1000, 1'b0, 64'd0);
        look(64'h1000, 1'b1, 1'b0, 64'h1004);
        upd(64'h1000, 1'b0, 64'd0);
        look(64'h1000, 1'b1, 1'b0, 64'h1004);
        upd(64'h1000, 1'b1, 64'h2000);
        look(64'h1000, 1'b1, 1'b0, 64'h1004);
        upd(64'h1000, 1'b1, 64'h2000);
        look(64'h1000, 1'b1, 1'b1, 64'h2000);
`else
        upd(64'h1000, 1'b0, 64'd0);
        look(64'h1000, 1'b0, 1'b0, 64'h1004);
        upd(64'h1000, 1'b1, 64'h2000);
        look(64'h1000, 1'b1, 1'b1, 64'h2000);
`endif

        // 0x1100 aliases to the same index as 0x1000.
        upd(64'h1100, 1'b1, 64'h3000);
        look(64'h1000, 1'b0, 1'b0, 64'h1004);
        look(64'h1100, 1'b1, 1'b1, 64'h3000);

        upd(64'h4000, 1'b0, 64'h7000);
        look(64'h4000, 1'b0, 1'b0, 64'h4004);
        step(64'h0, 1'b0, 64'h5000, 1'b1, 64'h6000, 1'b0, 1'b0, 1'b0, 64'd0);
        look(64'h5000, 1'b0, 1'b0, 64'h5004);

        look(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0);

        for (int n = 0; n < 300; n++) begin
            logic [63:0] a, b;
            a = pool[$urandom_range(0, 5)] | 64'($urandom_range(0, 3));
            b = pool[$urandom_range(0, 5)];
            step(a, ($urandom_range(0, 2) != 0), b, $urandom_range(0, 1) == 1,
                 {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 64'd0);
        end

        do_reset(1'b1);
        look(64'h1000, 1'b0, 1'b0, 64'h1004);
        look(64'h1100, 1'b0, 1'b0, 64'h1104);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter XLEN, default 64, address/target width in bits.
REQ-002 Parameter ENTRIES, default 64, table depth; power of two, minimum 2; IDXW = log2(ENTRIES).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc_if  input  XLEN  fetch-stage PC to look up.
REQ-006 pc_ex  input  XLEN  PC of the branch resolved in execute.
REQ-007 update_ex  input  1  execute stage holds a resolved control-transfer instruction; qualifies the update.
REQ-008 branch_taken_ex  input  1  resolved direction of the execute-stage branch.
REQ-009 target_addr_ex  input  XLEN  resolved target of the execute-stage branch.
REQ-010 predicted_target  output  XLEN  next fetch address predicted for pc_if.
REQ-011 predict_taken  output  1  prediction that pc_if is a taken branch.
REQ-012 hit  output  1  pc_if matches a valid table entry.

Function
REQ-013 Direct-mapped table; per entry: valid (1), tag (XLEN-IDXW-2), target (XLEN), counter (2).
REQ-014 Index = pc[IDXW+1:2]; tag = pc[XLEN-1:IDXW+2]; pc[1:0] ignored.
REQ-015 Lookup fully combinational, zero latency: hit = valid[idx(pc_if)] AND tag match.
REQ-016 predict_taken = hit AND counter[1] (see REQ-027 for the macro-absent case).
REQ-017 predicted_target = stored target when predict_taken, else pc_if + 4, modulo 2^XLEN (wraps at all-ones).
REQ-018 Update occurs on a clock edge only when update_ex=1 and reset=0; update_ex=0 leaves all state unchanged.
REQ-019 Taken update, entry matches pc_ex: target overwritten with target_addr_ex; counter increments, saturating at 3.
REQ-020 Taken update, entry misses (invalid or tag mismatch): allocate/replace; valid=1, tag and target written, counter=2 (weakly taken).
REQ-021 Not-taken update, entry matches: counter decrements, saturating at 0; valid, tag and target unchanged.
REQ-022 Not-taken update, entry misses: no state change; not-taken branches never allocate.
REQ-023 Same index looked up and updated in one cycle: lookup returns pre-update contents; no write-to-read bypass.
REQ-024 Outputs carry no registers; X-free whenever pc_if is known.

Reset
REQ-025 While reset=1 at a clock edge, all valid bits clear and all counters set to 1; tag/target contents are don't-care; reset overrides a simultaneous update_ex.
REQ-026 After reset: hit=0, predict_taken=0, predicted_target=pc_if+4 for every pc_if until the first taken update.

Configuration
REQ-027 Macro BTB_TWO_BIT_COUNTER_EN: when defined, counters behave per REQ-016, REQ-019 to REQ-021; when undefined, no counter storage exists, predict_taken = hit, a taken update allocates or overwrites the entry, and a not-taken update on a matching entry clears its valid bit.

Verification
REQ-028 Reset, then pc_if=0x1000 -> hit=0, predict_taken=0, predicted_target=0x1004.
REQ-029 Taken update pc_ex=0x1000, target 0x2000, then pc_if=0x1000 -> hit=1, predict_taken=1, predicted_target=0x2000.
REQ-030 With macro defined: after REQ-029, one not-taken update at 0x1000 -> hit=1, predict_taken=0, predicted_target=0x1004; a second not-taken -> counter 0; two taken updates -> predict_taken=1 again.
REQ-031 Aliasing (ENTRIES=64): entry for 0x1000, then taken update pc_ex=0x1100, target 0x3000 -> lookup 0x1000 hit=0, lookup 0x1100 predicted_target=0x3000.
REQ-032 Not-taken update for unallocated pc_ex=0x4000 -> lookup 0x4000 hit=0; update_ex=0 with branch_taken_ex=1 -> no allocation.
REQ-033 pc_if=0xFFFF_FFFF_FFFF_FFFC with miss -> predicted_target=0x0; reset asserted together with a taken update -> entry not allocated.
